// File: rtl/divider_iterative.sv
// Multi-cycle restoring divider with valid/ready on both sides; BITS_PER_CYCLE steps per clock.
// Define DIVIDER_SIGNED_EN to honour i_signed (RISC-V DIV/REM semantics); otherwise unsigned only.
module divider_iterative #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_signed,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_busy
);

  // state | meaning
  // IDLE  | waiting for a request
  // BUSY  | iterating restoring steps
  // DONE  | result held on outputs until consumed
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] orig_q;
  logic             dz_q;

  logic             accept;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             dz_in;

  logic [WIDTH:0]   rem_nx;
  logic [WIDTH-1:0] dvd_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign o_ready = (state == IDLE) || ((state == DONE) && i_ready);
  assign o_busy  = (state != IDLE);
  assign accept  = i_valid && o_ready;
  assign dz_in   = (i_divisor == '0);

`ifdef DIVIDER_SIGNED_EN
  logic sgn_a;
  logic sgn_b;
  logic ovf_in;
  logic neg_q;
  logic neg_r;
  logic ovf_q;

  assign sgn_a  = i_signed && i_dividend[WIDTH-1];
  assign sgn_b  = i_signed && i_divisor[WIDTH-1];
  assign mag_a  = sgn_a ? (~i_dividend + 1'b1) : i_dividend;
  assign mag_b  = sgn_b ? (~i_divisor + 1'b1) : i_divisor;
  assign ovf_in = i_signed && (i_dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&i_divisor);
`else
  logic unused_signed;

  assign unused_signed = i_signed;
  assign mag_a = i_dividend;
  assign mag_b = i_divisor;
`endif

  // Chain of restoring steps; the partial remainder carries one extra bit so
  // divisors with the MSB set do not lose the shifted-out bit.
  always_comb begin
    rem_nx = rem_q;
    dvd_nx = dvd_q;
    quo_nx = quo_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      rem_nx = {rem_nx[WIDTH-1:0], dvd_nx[WIDTH-1]};
      dvd_nx = {dvd_nx[WIDTH-2:0], 1'b0};
      if (rem_nx >= {1'b0, dsr_q}) begin
        rem_nx = rem_nx - {1'b0, dsr_q};
        quo_nx = {quo_nx[WIDTH-2:0], 1'b1};
      end else begin
        quo_nx = {quo_nx[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    quo_fix = quo_nx;
    rem_fix = rem_nx[WIDTH-1:0];
    if (dz_q) begin
      quo_fix = '1;
      rem_fix = orig_q;
    end
`ifdef DIVIDER_SIGNED_EN
    else if (ovf_q) begin
      quo_fix = orig_q;
      rem_fix = '0;
    end else begin
      if (neg_q) quo_fix = ~quo_nx + 1'b1;
      if (neg_r) rem_fix = ~rem_nx[WIDTH-1:0] + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      orig_q      <= '0;
      dz_q        <= 1'b0;
      o_valid     <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
`ifdef DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) state <= BUSY;
        end
        BUSY: begin
          rem_q <= rem_nx;
          dvd_q <= dvd_nx;
          quo_q <= quo_nx;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            state       <= DONE;
            o_valid     <= 1'b1;
            o_quotient  <= quo_fix;
            o_remainder <= rem_fix;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= accept ? BUSY : IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
        end
      endcase

      if (accept) begin
        rem_q  <= '0;
        quo_q  <= '0;
        dvd_q  <= mag_a;
        dsr_q  <= mag_b;
        orig_q <= i_dividend;
        dz_q   <= dz_in;
        cnt    <= CW'(N - 1);
`ifdef DIVIDER_SIGNED_EN
        neg_q  <= sgn_a ^ sgn_b;
        neg_r  <= sgn_a;
        ovf_q  <= ovf_in;
`endif
      end
    end
  end

endmodule

// File: tb/tb_divider_iterative.sv
// Directed bench for divider_iterative (WIDTH=32, BITS_PER_CYCLE=4).
// Expected values are hand-computed; signed expectations follow DIVIDER_SIGNED_EN.
module tb_divider_iterative;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        i_signed;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_quotient;
  logic [31:0] o_remainder;
  logic        o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  divider_iterative #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .i_signed    (i_signed),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Counts edges from the accepting edge until o_valid; bounded.
  task automatic wait_valid(input string tag);
    int edges;
    edges = 0;
    while (!o_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, " latency"}, 32'(edges), 32'd8);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] eq, input logic [31:0] er);
    i_dividend = a;
    i_divisor  = b;
    i_signed   = s;
    i_valid    = 1'b1;
    i_ready    = 1'b1;
    #1;
    check({tag, " accept ready"}, {31'd0, o_ready}, 32'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    wait_valid(tag);
    check({tag, " quotient"}, o_quotient, eq);
    check({tag, " remainder"}, o_remainder, er);
    check({tag, " done ready"}, {31'd0, o_ready}, 32'd1);
    @(posedge clk);
    #1;
    check({tag, " valid dropped"}, {31'd0, o_valid}, 32'd0);
  endtask

  initial begin
    int edges;
    int seen;
    rst        = 1'b1;
    i_valid    = 1'b0;
    i_ready    = 1'b1;
    i_signed   = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    #12;
    check("reset valid", {31'd0, o_valid}, 32'd0);
    check("reset busy", {31'd0, o_busy}, 32'd0);
    check("reset quotient", o_quotient, 32'd0);
    check("reset remainder", o_remainder, 32'd0);
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post-reset ready", {31'd0, o_ready}, 32'd1);

    run_op("basic 100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    run_op("divz unsigned", 32'hDEADBEEF, 32'd0, 1'b0, 32'hFFFFFFFF, 32'hDEADBEEF);
    run_op("divz signed", 32'hDEADBEEF, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hDEADBEEF);
    run_op("big divisor", 32'hFFFFFFFF, 32'h80000001, 1'b0, 32'd1, 32'h7FFFFFFE);
    run_op("near divisor", 32'hFFFFFFF0, 32'hFFFFFFF1, 1'b0, 32'd0, 32'hFFFFFFF0);
`ifdef DIVIDER_SIGNED_EN
    run_op("signed -7/2", 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_op("signed ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0);
    run_op("signed 7/-2", 32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1);
`else
    run_op("nosigned -7/2", 32'hFFFFFFF9, 32'd2, 1'b1, 32'h7FFFFFFC, 32'd1);
    run_op("nosigned ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 32'h80000000);
`endif
    run_op("unsigned -7/2", 32'hFFFFFFF9, 32'd2, 1'b0, 32'h7FFFFFFC, 32'd1);

    // Back-pressure then same-edge handoff and accept.
    i_ready    = 1'b0;
    i_dividend = 32'd200;
    i_divisor  = 32'd9;
    i_signed   = 1'b0;
    i_valid    = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    wait_valid("bp 200/9");
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp hold valid", {31'd0, o_valid}, 32'd1);
      check("bp hold quotient", o_quotient, 32'd22);
      check("bp hold remainder", o_remainder, 32'd2);
      check("bp ready low", {31'd0, o_ready}, 32'd0);
    end
    i_dividend = 32'd1000;
    i_divisor  = 32'd10;
    i_valid    = 1'b1;
    i_ready    = 1'b1;
    #1;
    check("b2b ready", {31'd0, o_ready}, 32'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    check("b2b valid dropped", {31'd0, o_valid}, 32'd0);
    check("b2b busy", {31'd0, o_busy}, 32'd1);
    wait_valid("b2b 1000/10");
    check("b2b quotient", o_quotient, 32'd100);
    check("b2b remainder", o_remainder, 32'd0);
    @(posedge clk);
    #1;

    // Operands churn during BUSY while i_valid stays high.
    i_dividend = 32'd50;
    i_divisor  = 32'd5;
    i_valid    = 1'b1;
    @(posedge clk);
    #1;
    edges = 0;
    while (!o_valid && edges < 20) begin
      check("churn ready low", {31'd0, o_ready}, 32'd0);
      i_dividend = $urandom;
      i_divisor  = $urandom;
      @(posedge clk);
      #1;
      edges++;
    end
    check("churn latency", 32'(edges), 32'd8);
    check("churn quotient", o_quotient, 32'd10);
    check("churn remainder", o_remainder, 32'd0);
    i_dividend = 32'd81;
    i_divisor  = 32'd9;
    #1;
    check("churn handoff ready", {31'd0, o_ready}, 32'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    check("churn reaccept busy", {31'd0, o_busy}, 32'd1);
    wait_valid("churn 81/9");
    check("churn2 quotient", o_quotient, 32'd9);
    check("churn2 remainder", o_remainder, 32'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-operation.
    i_dividend = 32'd9999;
    i_divisor  = 32'd3;
    i_valid    = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst busy", {31'd0, o_busy}, 32'd0);
    check("midrst valid", {31'd0, o_valid}, 32'd0);
    check("midrst quotient", o_quotient, 32'd0);
    check("midrst remainder", o_remainder, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (o_valid) seen = 1;
    end
    check("midrst no valid pulse", 32'(seen), 32'd0);
    run_op("after reset 9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
